instr_bundle_queue: RTL and testbench

//   Decoupling queue between IF and ID stages. Buffers fetched 32-bit VLIW bundles and their PCs.

---
 rtl/instr_bundle_queue_pkg.sv | 26 ++
 rtl/instr_bundle_queue_if.sv | 38 +++
 rtl/instr_bundle_queue_storage.sv | 32 +++
 rtl/instr_bundle_queue.sv | 96 +++++++++
 tb/tb_instr_bundle_queue.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_bundle_queue_pkg.sv
// Shared constants and types for the IF->ID instruction bundle queue.
// A bundle is {aluInstr, memInstr}; each queue entry pairs a bundle with its PC.
package instr_bundle_queue_pkg;

  localparam int unsigned BUNDLE_W = 32;
  localparam int unsigned SLOT_W   = 16;
  localparam int unsigned PC_W     = 32;

  localparam logic [SLOT_W-1:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic [BUNDLE_W-1:0] bundle;
    logic [PC_W-1:0]     pc;
  } ibq_entry_t;

  // ALU slot occupies the upper half of a bundle
  function automatic logic [SLOT_W-1:0] alu_slot(input logic [BUNDLE_W-1:0] b);
    return b[BUNDLE_W-1:SLOT_W];
  endfunction

  // MEM slot occupies the lower half of a bundle
  function automatic logic [SLOT_W-1:0] mem_slot(input logic [BUNDLE_W-1:0] b);
    return b[SLOT_W-1:0];
  endfunction

endpackage

// File: rtl/instr_bundle_queue_if.sv
// Handshake bundle between the IF stage (producer), the ID stage (consumer)
// and the instruction bundle queue. The queue connects through the slave
// modport; the pipeline side (or a bench) drives through master.
interface instr_bundle_queue_if #(
  parameter int DEPTH = 4
) ();
  import instr_bundle_queue_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  // IF -> queue
  logic                pushValid;
  logic [BUNDLE_W-1:0] pushBundle;
  logic [PC_W-1:0]     pushPC;
  logic                pushReady;

  // queue -> ID
  logic                popReady;
  logic                popValid;
  logic [SLOT_W-1:0]   aluInstr;
  logic [SLOT_W-1:0]   memInstr;
  logic [PC_W-1:0]     popPC;

  // redirect and status
  logic                flush;
  logic [PTR_W:0]      count;

  modport master (
    output pushValid, pushBundle, pushPC, popReady, flush,
    input  pushReady, popValid, aluInstr, memInstr, popPC, count
  );

  modport slave (
    input  pushValid, pushBundle, pushPC, popReady, flush,
    output pushReady, popValid, aluInstr, memInstr, popPC, count
  );

endinterface

// File: rtl/instr_bundle_queue_storage.sv
// Entry storage for the instruction bundle queue: DEPTH x {bundle, pc}
// registers with one synchronous write port and one asynchronous read port.
// Data is deliberately not reset; validity is tracked by the queue control.
module bundle_queue_storage
  import instr_bundle_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wrEn,
  input  logic [PTR_W-1:0] i_wrAddr,
  input  ibq_entry_t       i_wrData,
  input  logic [PTR_W-1:0] i_rdAddr,
  output ibq_entry_t       o_rdData
);

  ibq_entry_t r_mem [DEPTH];

  // Write the incoming entry at the write pointer
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  // Head entry is read combinationally
  always_comb begin
    o_rdData = r_mem[i_rdAddr];
  end

endmodule

// File: rtl/instr_bundle_queue.sv
// instr_bundle_queue: decoupling FIFO between IF and ID.
// Buffers fetched 32-bit VLIW bundles with their PCs and presents the head to
// ID split into ALU (31:16) and MEM (15:0) slots, NOP-substituted when empty.
// pushReady doubles as the IF pcWrite; it depends only on registered state.
// flush (redirect) empties the queue; priority is reset > flush > push/pop.
// Optional feature macro: IBQ_BYPASS_EN -- lets a bundle pushed into an empty
// queue be consumed by ID in the same cycle without ever being stored.
module instr_bundle_queue
  import instr_bundle_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input logic                 clk,
  input logic                 reset,
  instr_bundle_queue_if.slave bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W:0]   r_count;

  logic       w_full;
  logic       w_empty;
  logic       w_pushReady;
  logic       w_bypass;
  logic       w_pushFire;
  logic       w_popFire;
  logic       w_headValid;
  ibq_entry_t w_wrEntry;
  ibq_entry_t w_rdEntry;
  ibq_entry_t w_head;

  bundle_queue_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk      (clk),
    .i_wrEn   (w_pushFire),
    .i_wrAddr (r_wrPtr),
    .i_wrData (w_wrEntry),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_rdEntry)
  );

  // Handshake qualification and same-cycle bypass detection
  always_comb begin
    w_full      = (r_count == FULL_CNT);
    w_empty     = (r_count == '0);
    w_pushReady = !w_full && !reset;
`ifdef IBQ_BYPASS_EN
    w_bypass    = w_empty && bus.pushValid && bus.popReady && !bus.flush && !reset;
`else
    w_bypass    = 1'b0;
`endif
    // A bypassed bundle is handed straight to ID, so it is neither stored nor popped
    w_pushFire  = bus.pushValid && w_pushReady && !bus.flush && !w_bypass;
    w_popFire   = !w_empty && bus.popReady;
    w_headValid = !reset && (!w_empty || w_bypass);
    w_wrEntry   = '{bundle: bus.pushBundle, pc: bus.pushPC};
    w_head      = w_bypass ? w_wrEntry : w_rdEntry;
  end

  // Pointer and occupancy tracking; flush and reset drop everything in flight
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushFire) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_popFire) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_pushFire && !w_popFire) begin
        r_count <= r_count + 1'b1;
      end else if (w_popFire && !w_pushFire) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Head presentation with NOP substitution when nothing is valid
  always_comb begin
    bus.pushReady = w_pushReady;
    bus.popValid  = w_headValid;
    bus.aluInstr  = w_headValid ? alu_slot(w_head.bundle) : NOP_INSTR;
    bus.memInstr  = w_headValid ? mem_slot(w_head.bundle) : NOP_INSTR;
    bus.popPC     = w_headValid ? w_head.pc : '0;
    bus.count     = reset ? '0 : r_count;
  end

endmodule

// File: tb/tb_instr_bundle_queue.sv
// Bench for instr_bundle_queue (DEPTH=4): directed vector table, a wrap-around
// sequence, then randomized traffic against a queue-based reference model.
module tb_instr_bundle_queue;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  instr_bundle_queue_if #(.DEPTH(DEPTH)) bus ();

  instr_bundle_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total;
  int unsigned n_pass;

  typedef struct {
    logic        rst;
    logic        pv;
    logic [31:0] bundle;
    logic [31:0] pc;
    logic        pr;
    logic        fl;
    logic        e_push;
    logic        e_pv;
    logic [31:0] e_bundle;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  typedef struct {
    logic [31:0] b;
    logic [31:0] pc;
  } mentry_t;

  mentry_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic rst, input logic pv, input logic [31:0] bundle,
                     input logic [31:0] pc, input logic pr, input logic fl,
                     input logic e_push, input logic e_pv, input logic [31:0] e_bundle,
                     input logic [31:0] e_pc, input logic [2:0] e_cnt);
    vec_t v;
    v.rst = rst; v.pv = pv; v.bundle = bundle; v.pc = pc; v.pr = pr; v.fl = fl;
    v.e_push = e_push; v.e_pv = e_pv; v.e_bundle = e_bundle; v.e_pc = e_pc; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  task automatic set_in(input logic rst, input logic pv, input logic [31:0] bundle,
                        input logic [31:0] pc, input logic pr, input logic fl);
    reset          = rst;
    bus.pushValid  = pv;
    bus.pushBundle = bundle;
    bus.pushPC     = pc;
    bus.popReady   = pr;
    bus.flush      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_push, input logic e_pv,
                           input logic [31:0] e_bundle, input logic [31:0] e_pc,
                           input logic [2:0] e_cnt);
    logic [31:0] eb;
    eb = e_bundle;
    chk({tag, " pushReady"}, {31'd0, bus.pushReady}, {31'd0, e_push});
    chk({tag, " popValid"},  {31'd0, bus.popValid},  {31'd0, e_pv});
    chk({tag, " aluInstr"},  {16'd0, bus.aluInstr},  {16'd0, eb[31:16]});
    chk({tag, " memInstr"},  {16'd0, bus.memInstr},  {16'd0, eb[15:0]});
    chk({tag, " popPC"},     bus.popPC,              e_pc);
    chk({tag, " count"},     {29'd0, bus.count},     {29'd0, e_cnt});
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    set_in(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);

    // reset held for 3 cycles (first edge unchecked), then released
    add(1, 0, 32'h0, 32'h0, 0, 0,  0, 0, 32'h0, 32'h0, 0);
    add(1, 1, 32'hFFFF_FFFF, 32'h44, 0, 0,  0, 0, 32'h0, 32'h0, 0);
    add(1, 0, 32'h0, 32'h0, 0, 0,  0, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0, 32'h0, 0, 0,  1, 0, 32'h0, 32'h0, 0);
    // single push, visible the next cycle, then popped
    add(0, 1, 32'h1234_ABCD, 32'h40, 0, 0,  1, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0, 32'h0, 0, 0,  1, 1, 32'h1234_ABCD, 32'h40, 1);
    add(0, 0, 32'h0, 32'h0, 1, 0,  1, 1, 32'h1234_ABCD, 32'h40, 1);
    add(0, 0, 32'h0, 32'h0, 0, 0,  1, 0, 32'h0, 32'h0, 0);
    // fill to full; 5th push refused, also refused when a pop coincides at full
    add(0, 1, 32'h1111_1111, 32'h00, 0, 0,  1, 0, 32'h0, 32'h0, 0);
    add(0, 1, 32'h2222_2222, 32'h04, 0, 0,  1, 1, 32'h1111_1111, 32'h00, 1);
    add(0, 1, 32'h3333_3333, 32'h08, 0, 0,  1, 1, 32'h1111_1111, 32'h00, 2);
    add(0, 1, 32'h4444_4444, 32'h0C, 0, 0,  1, 1, 32'h1111_1111, 32'h00, 3);
    add(0, 1, 32'h5555_5555, 32'h10, 0, 0,  0, 1, 32'h1111_1111, 32'h00, 4);
    add(0, 1, 32'h5555_5555, 32'h10, 1, 0,  0, 1, 32'h1111_1111, 32'h00, 4);
    add(0, 0, 32'h0, 32'h0, 1, 0,  1, 1, 32'h2222_2222, 32'h04, 3);
    add(0, 0, 32'h0, 32'h0, 1, 0,  1, 1, 32'h3333_3333, 32'h08, 2);
    add(0, 0, 32'h0, 32'h0, 1, 0,  1, 1, 32'h4444_4444, 32'h0C, 1);
    add(0, 0, 32'h0, 32'h0, 0, 0,  1, 0, 32'h0, 32'h0, 0);
    // three queued, then flush together with a push
    add(0, 1, 32'hC1C1_C1C1, 32'h100, 0, 0,  1, 0, 32'h0, 32'h0, 0);
    add(0, 1, 32'hC2C2_C2C2, 32'h104, 0, 0,  1, 1, 32'hC1C1_C1C1, 32'h100, 1);
    add(0, 1, 32'hC3C3_C3C3, 32'h108, 0, 0,  1, 1, 32'hC1C1_C1C1, 32'h100, 2);
    add(0, 1, 32'hDEAD_BEEF, 32'h200, 0, 1,  1, 1, 32'hC1C1_C1C1, 32'h100, 3);
    add(0, 0, 32'h0, 32'h0, 0, 0,  1, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0, 32'h0, 1, 0,  1, 0, 32'h0, 32'h0, 0);
    // push and pop together on an empty queue
`ifdef IBQ_BYPASS_EN
    add(0, 1, 32'h8888_7777, 32'h80, 1, 0,  1, 1, 32'h8888_7777, 32'h80, 0);
    add(0, 0, 32'h0, 32'h0, 0, 0,  1, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0, 32'h0, 1, 0,  1, 0, 32'h0, 32'h0, 0);
`else
    add(0, 1, 32'h8888_7777, 32'h80, 1, 0,  1, 0, 32'h0, 32'h0, 0);
    add(0, 0, 32'h0, 32'h0, 0, 0,  1, 1, 32'h8888_7777, 32'h80, 1);
    add(0, 0, 32'h0, 32'h0, 1, 0,  1, 1, 32'h8888_7777, 32'h80, 1);
`endif
    add(0, 0, 32'h0, 32'h0, 0, 0,  1, 0, 32'h0, 32'h0, 0);

    tick();
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].rst, tbl[i].pv, tbl[i].bundle, tbl[i].pc, tbl[i].pr, tbl[i].fl);
      #4;
      check_all($sformatf("row%0d", i), tbl[i].e_push, tbl[i].e_pv,
                tbl[i].e_bundle, tbl[i].e_pc, tbl[i].e_cnt);
      tick();
    end

    // wrap-around: prefill two, then push+pop together for 10 cycles
    begin
      logic [31:0] pc;
      pc = 32'h300;
      set_in(0, 1, {~pc[15:0], pc[15:0]}, pc, 0, 0);
      tick();
      pc = 32'h304;
      set_in(0, 1, {~pc[15:0], pc[15:0]}, pc, 0, 0);
      tick();
      for (int k = 0; k < 10; k++) begin
        logic [31:0] hp;
        pc = 32'h308 + 32'(4 * k);
        hp = 32'h300 + 32'(4 * k);
        set_in(0, 1, {~pc[15:0], pc[15:0]}, pc, 1, 0);
        #4;
        check_all($sformatf("wrap%0d", k), 1'b1, 1'b1, {~hp[15:0], hp[15:0]}, hp, 3'd2);
        tick();
      end
      set_in(0, 0, '0, '0, 0, 1);
      tick();
    end

    // randomized traffic against a reference queue
    mq.delete();
    for (int c = 0; c < 800; c++) begin
      logic        rst, pv, pr, fl, byp, e_push, e_pv;
      logic [31:0] bnd, pc, e_b, e_pc;
      int          sz;
      rst = (c == 0) || ($urandom_range(0, 59) == 0);
      fl  = ($urandom_range(0, 24) == 0);
      pv  = ($urandom_range(0, 9) < 6);
      pr  = ($urandom_range(0, 9) < 5);
      bnd = $urandom;
      pc  = $urandom & 32'hFFFF_FFFC;
      set_in(rst, pv, bnd, pc, pr, fl);
      sz = mq.size();
`ifdef IBQ_BYPASS_EN
      byp = !rst && sz == 0 && pv && pr && !fl;
`else
      byp = 1'b0;
`endif
      e_push = !rst && sz != DEPTH;
      e_pv   = !rst && (sz != 0 || byp);
      e_b    = '0;
      e_pc   = '0;
      if (e_pv) begin
        if (byp) begin e_b = bnd; e_pc = pc; end
        else begin e_b = mq[0].b; e_pc = mq[0].pc; end
      end
      #4;
      check_all($sformatf("rand%0d", c), e_push, e_pv, e_b, e_pc, rst ? 3'd0 : 3'(sz));
      if (rst || fl) mq.delete();
      else if (!byp) begin
        if (sz != 0 && pr) void'(mq.pop_front());
        if (pv && sz != DEPTH) mq.push_back('{b: bnd, pc: pc});
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
